instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch sequencer (IDLE/REQ/LOAD/EXEC/HALTED)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        begin fetching from pc (honoured in IDLE only)
//   mem_rdata    instruction word from program memory
//   mem_ready    mem_rdata valid for the current request
//   mem_req      memory read request (REQ state only)
//   mem_addr     memory read address (tracks pc)
//   exec_done    control unit finished the current instruction
//   branch_en    load branch_addr into pc (qualified by exec_done)
//   branch_addr  branch target
//   halt         stop after current instruction (qualified by exec_done)
//   ir_data      instruction word for the instruction register
//   ir_w         instruction-register write strobe, high only in LOAD
//   pc           program counter
//   busy         high outside IDLE and HALTED
//   fetch_err    sticky memory-timeout flag

module instr_fetch #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [9:0]  mem_addr,
    input  logic        exec_done,
    input  logic        branch_en,
    input  logic [9:0]  branch_addr,
    input  logic        halt,
    output logic [15:0] ir_data,
    output logic        ir_w,
    output logic [9:0]  pc,
    output logic        busy,
    output logic        fetch_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [9:0]    r_pc;
    logic [15:0]   r_ir_data;
    logic          r_ir_w;
    logic          r_fetch_err;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_timeout;

    assign w_cnt_inc = r_wait_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CW'(TIMEOUT));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_REQ;
            S_REQ: begin
                if (mem_ready)      w_next_state = S_LOAD;
                else if (w_timeout) w_next_state = S_HALTED;
            end
            S_LOAD:   w_next_state = S_EXEC;
            S_EXEC: begin
                if (exec_done) w_next_state = halt ? S_HALTED : S_REQ;
            end
            S_HALTED: w_next_state = S_HALTED;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= 10'd0;
            r_ir_data   <= 16'd0;
            r_ir_w      <= 1'b0;
            r_fetch_err <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            // Strobe is a flop set from the next state so it is glitch-free
            // and coincides exactly with the LOAD cycle.
            r_ir_w  <= (w_next_state == S_LOAD);
            case (r_state)
                S_REQ: begin
                    if (mem_ready) begin
                        r_ir_data  <= mem_rdata;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        if (w_timeout) r_fetch_err <= 1'b1;
                    end
                end
                S_LOAD: r_pc <= r_pc + 10'd1;
                S_EXEC: begin
                    // halt wins over branch; pc stays put when halting
                    if (exec_done && !halt && branch_en) r_pc <= branch_addr;
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (r_state == S_REQ);
    assign mem_addr  = r_pc;
    assign ir_data   = r_ir_data;
    assign ir_w      = r_ir_w;
    assign pc        = r_pc;
    assign busy      = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch

module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        exec_done = 1'b0;
    logic        branch_en = 1'b0;
    logic [9:0]  branch_addr = 10'd0;
    logic        halt = 1'b0;
    logic [15:0] ir_data;
    logic        ir_w;
    logic [9:0]  pc;
    logic        busy;
    logic        fetch_err;

    int n_pass = 0;
    int n_total = 0;

    instr_fetch #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .exec_done(exec_done), .branch_en(branch_en),
        .branch_addr(branch_addr), .halt(halt),
        .ir_data(ir_data), .ir_w(ir_w), .pc(pc),
        .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic        ready;
        logic [15:0] rdata;
        logic        done;
        logic        br;
        logic [9:0]  baddr;
        logic        halt;
        logic        e_req;
        logic [9:0]  e_addr;
        logic        e_irw;
        logic [15:0] e_ird;
        logic [9:0]  e_pc;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(logic st, logic rdy, logic [15:0] rd, logic dn,
                                logic br, logic [9:0] ba, logic hl,
                                logic ereq, logic [9:0] eaddr, logic eirw,
                                logic [15:0] eird, logic [9:0] epc, logic ebusy);
        vec_t v;
        v.start = st;  v.ready = rdy; v.rdata = rd; v.done = dn;
        v.br = br;     v.baddr = ba;  v.halt = hl;
        v.e_req = ereq; v.e_addr = eaddr; v.e_irw = eirw;
        v.e_ird = eird; v.e_pc = epc; v.e_busy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    task automatic drive_idle_inputs();
        start = 0; mem_ready = 0; mem_rdata = 16'd0; exec_done = 0;
        branch_en = 0; branch_addr = 10'd0; halt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle_inputs();
        rst = 0;
        #2;
        rst = 1;
    endtask

    vec_t vecs[19];
    int   irw_seen;

    initial begin
        // reset state, checked with no clock edge after assertion
        #3;
        chk("rst_req",  {15'd0, mem_req}, 16'd0);
        chk("rst_addr", {6'd0, mem_addr}, 16'd0);
        chk("rst_irw",  {15'd0, ir_w}, 16'd0);
        chk("rst_ird",  ir_data, 16'd0);
        chk("rst_pc",   {6'd0, pc}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_err",  {15'd0, fetch_err}, 16'd0);
        @(negedge clk);
        rst = 1;

        //            st rdy rdata      dn br baddr    hl  req addr    irw ird        pc      busy
        vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 10'h000, 0,  0, 10'h000, 0, 16'h0000, 10'h000, 0);
        vecs[1]  = mk(1, 1, 16'h1234, 0, 0, 10'h000, 0,  1, 10'h000, 0, 16'h0000, 10'h000, 1);
        vecs[2]  = mk(0, 1, 16'h1234, 0, 0, 10'h000, 0,  0, 10'h000, 1, 16'h1234, 10'h000, 1);
        vecs[3]  = mk(0, 0, 16'h0000, 0, 0, 10'h000, 0,  0, 10'h001, 0, 16'h1234, 10'h001, 1);
        vecs[4]  = mk(1, 0, 16'h0000, 0, 1, 10'h2AA, 1,  0, 10'h001, 0, 16'h1234, 10'h001, 1);
        vecs[5]  = mk(0, 0, 16'h0000, 1, 0, 10'h000, 0,  1, 10'h001, 0, 16'h1234, 10'h001, 1);
        vecs[6]  = mk(0, 0, 16'hABCD, 0, 0, 10'h000, 0,  1, 10'h001, 0, 16'h1234, 10'h001, 1);
        vecs[7]  = mk(0, 1, 16'hABCD, 0, 0, 10'h000, 0,  0, 10'h001, 1, 16'hABCD, 10'h001, 1);
        vecs[8]  = mk(0, 0, 16'h0000, 0, 0, 10'h000, 0,  0, 10'h002, 0, 16'hABCD, 10'h002, 1);
        vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 10'h000, 0,  0, 10'h002, 0, 16'hABCD, 10'h002, 1);
        vecs[10] = mk(0, 0, 16'h0000, 1, 0, 10'h000, 0,  1, 10'h002, 0, 16'hABCD, 10'h002, 1);
        vecs[11] = mk(0, 1, 16'h5555, 0, 0, 10'h000, 0,  0, 10'h002, 1, 16'h5555, 10'h002, 1);
        vecs[12] = mk(0, 0, 16'h0000, 0, 0, 10'h000, 0,  0, 10'h003, 0, 16'h5555, 10'h003, 1);
        vecs[13] = mk(0, 0, 16'h0000, 1, 1, 10'h3FF, 0,  1, 10'h3FF, 0, 16'h5555, 10'h3FF, 1);
        vecs[14] = mk(0, 1, 16'h0F0F, 0, 0, 10'h000, 0,  0, 10'h3FF, 1, 16'h0F0F, 10'h3FF, 1);
        vecs[15] = mk(0, 0, 16'h0000, 0, 0, 10'h000, 0,  0, 10'h000, 0, 16'h0F0F, 10'h000, 1);
        vecs[16] = mk(0, 0, 16'h0000, 1, 1, 10'h155, 1,  0, 10'h000, 0, 16'h0F0F, 10'h000, 0);
        vecs[17] = mk(1, 0, 16'h0000, 0, 0, 10'h000, 0,  0, 10'h000, 0, 16'h0F0F, 10'h000, 0);
        vecs[18] = mk(1, 1, 16'h7777, 1, 1, 10'h100, 0,  0, 10'h000, 0, 16'h0F0F, 10'h000, 0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            start = vecs[i].start; mem_ready = vecs[i].ready; mem_rdata = vecs[i].rdata;
            exec_done = vecs[i].done; branch_en = vecs[i].br;
            branch_addr = vecs[i].baddr; halt = vecs[i].halt;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req", i),  {15'd0, mem_req}, {15'd0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i), {6'd0, mem_addr}, {6'd0, vecs[i].e_addr});
            chk($sformatf("v%0d_irw", i),  {15'd0, ir_w}, {15'd0, vecs[i].e_irw});
            chk($sformatf("v%0d_ird", i),  ir_data, vecs[i].e_ird);
            chk($sformatf("v%0d_pc", i),   {6'd0, pc}, {6'd0, vecs[i].e_pc});
            chk($sformatf("v%0d_busy", i), {15'd0, busy}, {15'd0, vecs[i].e_busy});
            chk($sformatf("v%0d_err", i),  {15'd0, fetch_err}, 16'd0);
        end

        // memory timeout: 15 REQ cycles without mem_ready
        do_reset();
        @(negedge clk);
        start = 1;
        @(posedge clk); #1;
        chk("to_enter_req", {15'd0, mem_req}, 16'd1);
        irw_seen = 0;
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            start = 0;
            @(posedge clk); #1;
            if (ir_w) irw_seen++;
            chk($sformatf("to_req_c%0d", i), {14'd0, fetch_err, mem_req}, 16'd1);
        end
        @(posedge clk); #1;
        chk("to_err",    {15'd0, fetch_err}, 16'd1);
        chk("to_req_lo", {15'd0, mem_req}, 16'd0);
        chk("to_busy",   {15'd0, busy}, 16'd0);
        chk("to_pc",     {6'd0, pc}, 16'd0);
        chk("to_irw_cnt", 16'(irw_seen), 16'd0);
        @(negedge clk);
        start = 1; mem_ready = 1;
        @(posedge clk); #1;
        chk("to_start_ign", {14'd0, busy, mem_req}, 16'd0);
        chk("to_err_stick", {15'd0, fetch_err}, 16'd1);
        @(negedge clk);
        start = 0;
        rst = 0;
        #1;
        chk("to_err_clr", {15'd0, fetch_err}, 16'd0);
        rst = 1;

        // asynchronous reset while in LOAD of the second fetch
        @(negedge clk);
        start = 1; mem_ready = 1; mem_rdata = 16'hBEEF;
        @(negedge clk); start = 0;           // REQ
        @(negedge clk);                      // LOAD
        @(negedge clk); exec_done = 1;       // EXEC
        @(negedge clk); exec_done = 0;       // REQ
        @(posedge clk); #1;                  // LOAD
        chk("ar_irw_pre", {15'd0, ir_w}, 16'd1);
        chk("ar_pc_pre",  {6'd0, pc}, 16'd1);
        #2;
        rst = 0;
        #1;
        chk("ar_irw", {15'd0, ir_w}, 16'd0);
        chk("ar_pc",  {6'd0, pc}, 16'd0);
        chk("ar_ird", ir_data, 16'd0);
        chk("ar_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("ar_idle%0d", i), {14'd0, busy, mem_req}, 16'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
